// File: rtl/iter_divider_if.sv
// Request/response bundle between the EX stage and the iterative divider.
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/iter_divider.sv
// Restoring divider: one quotient bit per clock on operand magnitudes,
// signs applied in a final fix-up cycle. Results and flags are registered.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    iter_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             a_neg_s, b_neg_s, ge_s;
    logic [WIDTH:0]   shifted_s, diff_s;

    assign a_neg_s   = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg_s   = bus.is_signed & bus.divisor[WIDTH-1];
    assign shifted_s = {rem_q, quo_q[WIDTH-1]};
    assign diff_s    = shifted_s - {1'b0, dvs_q};
    // The shifted remainder is below 2*divisor, so a set top bit means it
    // already exceeds the divisor; otherwise a wrapped difference means borrow.
    assign ge_s      = shifted_s[WIDTH] | ~diff_s[WIDTH];

    // Next-state, datapath and result computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    quo_d   = a_neg_s ? ({WIDTH{1'b0}} - bus.dividend) : bus.dividend;
                    dvs_d   = b_neg_s ? ({WIDTH{1'b0}} - bus.divisor) : bus.divisor;
                    q_neg_d = a_neg_s ^ b_neg_s;
                    r_neg_d = a_neg_s;
                    zero_d  = (bus.divisor == {WIDTH{1'b0}});
                    rem_d   = {WIDTH{1'b0}};
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (ge_s) begin
                    rem_d = diff_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quotient_d  = {WIDTH{1'b1}};
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = q_neg_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
                    remainder_d = r_neg_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
                    dbz_d       = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any divide in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            dvd_q       <= {WIDTH{1'b0}};
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dvd_q       <= dvd_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed corner cases, timing,
// back-to-back, mid-operation reset and a randomized reference-model regression.
module tb_iter_divider;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    iter_divider_if #(.WIDTH(W)) bus ();
    iter_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain language-level arithmetic on the operands.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb, q64, r64;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (sgn) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            q64 = sa / sb;
            r64 = sa % sb;
            q   = q64[31:0];
            r   = r64[31:0];
            z   = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    task automatic wait_done(output int lat, output int busy_cnt, output logic busy_at_done);
        lat = -1;
        busy_cnt = 0;
        busy_at_done = 1'b1;
        if (bus.busy) busy_cnt++;
        for (int n = 1; n <= LAT + 8; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = n;
                busy_at_done = bus.busy;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = sgn; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int lat, bc;
        logic bd, z;
        logic [31:0] q, r;
        launch(sgn, a, b);
        wait_done(lat, bc, bd);
        ref_div(sgn, a, b, q, r, z);
        check_eq({tag, ".lat"}, 64'(lat), 64'(LAT));
        check_eq({tag, ".q"}, 64'(bus.quotient), 64'(q));
        check_eq({tag, ".r"}, 64'(bus.remainder), 64'(r));
        check_eq({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(z));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [8] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000,
                                     32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd7};
        int sel = $urandom_range(0, 9);
        if (sel < 3) return corners[$urandom_range(0, 7)];
        else if (sel < 5) return 32'($urandom_range(1, 1000));
        else return 32'($urandom);
    endfunction

    initial begin
        int lat, bc, cnt;
        logic bd;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = 32'd0; bus.divisor = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.busy", 64'(bus.busy), 64'd0);
        check_eq("rst.done", 64'(bus.done), 64'd0);
        check_eq("rst.q", 64'(bus.quotient), 64'd0);
        check_eq("rst.r", 64'(bus.remainder), 64'd0);
        check_eq("rst.dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk) rst = 1'b0;

        // 100 / 7 with explicit latency, busy-window and single-pulse checks
        launch(1'b0, 32'd100, 32'd7);
        wait_done(lat, bc, bd);
        check_eq("u100_7.lat", 64'(lat), 64'(LAT));
        check_eq("u100_7.busycnt", 64'(bc), 64'(LAT));
        check_eq("u100_7.busy_at_done", 64'(bd), 64'd0);
        check_eq("u100_7.q", 64'(bus.quotient), 64'd14);
        check_eq("u100_7.r", 64'(bus.remainder), 64'd2);
        check_eq("u100_7.dbz", 64'(bus.div_by_zero), 64'd0);
        @(posedge clk); #1;
        check_eq("u100_7.done_once", 64'(bus.done), 64'd0);
        check_eq("u100_7.q_held", 64'(bus.quotient), 64'd14);

        run_check("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check_eq("s_m7_2.q_abs", 64'(bus.quotient), 64'hFFFF_FFFD);
        check_eq("s_m7_2.r_abs", 64'(bus.remainder), 64'hFFFF_FFFF);
        run_check("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        check_eq("u_m7_2.q_abs", 64'(bus.quotient), 64'h7FFF_FFFC);
        run_check("s_dbz", 1'b1, 32'h0000_1234, 32'd0);
        check_eq("s_dbz.r_abs", 64'(bus.remainder), 64'h1234);
        run_check("u_dbz", 1'b0, 32'h0000_1234, 32'd0);
        check_eq("u_dbz.flag", 64'(bus.div_by_zero), 64'd1);
        run_check("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("s_ovf.q_abs", 64'(bus.quotient), 64'h8000_0000);
        run_check("u_ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("u_ones.q_abs", 64'(bus.quotient), 64'd1);
        run_check("s_neg_div", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_check("s_minus1", 1'b1, 32'hFFFF_FFFF, 32'd1);

        // 50 / 5 with an ignored start at cycle 10, then back-to-back 9 / 3
        launch(1'b0, 32'd50, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 10;
        lat = -1;
        for (int n = 11; n <= LAT + 8; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = n; break; end
        end
        check_eq("b2b.first_lat", 64'(lat), 64'(LAT));
        check_eq("b2b.first_q", 64'(bus.quotient), 64'd10);
        check_eq("b2b.first_r", 64'(bus.remainder), 64'd0);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_eq("b2b.busy_rise", 64'(bus.busy), 64'd1);
        check_eq("b2b.q_held", 64'(bus.quotient), 64'd10);
        wait_done(lat, bc, bd);
        check_eq("b2b.second_lat", 64'(lat), 64'(LAT));
        check_eq("b2b.second_q", 64'(bus.quotient), 64'd3);
        check_eq("b2b.second_r", 64'(bus.remainder), 64'd0);

        // reset in the middle of 1000 / 10
        launch(1'b0, 32'd1000, 32'd10);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst.busy", 64'(bus.busy), 64'd0);
        check_eq("midrst.done", 64'(bus.done), 64'd0);
        check_eq("midrst.q", 64'(bus.quotient), 64'd0);
        check_eq("midrst.r", 64'(bus.remainder), 64'd0);
        check_eq("midrst.dbz", 64'(bus.div_by_zero), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < LAT + 4; n++) begin
            @(posedge clk); #1;
            if (bus.done) cnt++;
        end
        check_eq("midrst.no_done", 64'(cnt), 64'd0);
        run_check("postrst", 1'b0, 32'd1000, 32'd10);
        check_eq("postrst.q_abs", 64'(bus.quotient), 64'd100);

        // randomized regression against the reference model
        for (int i = 0; i < 1000; i++) begin
            run_check("rand", 1'($urandom_range(0, 1)), pick_operand(), pick_operand());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
